// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAULT
   } state_e;

   localparam int unsigned RST_CYCLES_DEF    = 16;
   localparam int unsigned LOCK_TIMEOUT_DEF  = 65535;
   localparam int unsigned STABLE_CYCLES_DEF = 1024;
   localparam int unsigned MAX_RETRIES_DEF   = 3;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned RETRY_W = 4;
   localparam int unsigned LOSS_W  = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by reset.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock qualification sequencer: pulses PLL reset, waits for a
// stable lock, then releases system reset; retries and faults on timeouts.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
   parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned MAX_RETRIES   = MAX_RETRIES_DEF
) (
   input  logic               in_clk25,
   input  logic               in_reset,
   input  logic               pll_locked,
   input  logic               relock_req,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  lock_loss_cnt
);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   state_e               state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [RETRY_W-1:0]   retry_nxt;
   logic [LOSS_W-1:0]    loss_nxt;
   logic                 locked_s;

   sync2 u_sync_locked (
      .clk (in_clk25),
      .rst (in_reset),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // State, shared counter (cleared on every state change) and status counters.
   always_ff @(posedge in_clk25) begin
      if (in_reset) begin
         state         <= ST_PLL_RST;
         cnt           <= '0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         retry_cnt     <= retry_nxt;
         lock_loss_cnt <= loss_nxt;
      end
   end

   // Next-state and counter updates.
   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      loss_nxt  = lock_loss_cnt;
      case (state)
         ST_PLL_RST: begin
            if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // A lock seen in the final timeout cycle wins over the retry.
            if (locked_s) begin
               state_nxt = ST_STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               retry_nxt = retry_cnt + RETRY_W'(1);
               state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_PLL_RST;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_nxt = ST_WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = ST_RUN;
               retry_nxt = '0;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_nxt = ST_PLL_RST;
               if (lock_loss_cnt != '1) loss_nxt = lock_loss_cnt + LOSS_W'(1);
            end else if (relock_req) begin
               state_nxt = ST_PLL_RST;
            end
         end
         ST_FAULT: begin
            if (relock_req) begin
               state_nxt = ST_PLL_RST;
               retry_nxt = '0;
            end
         end
         default: state_nxt = ST_PLL_RST;
      endcase
   end

   // Glitch-free status outputs decoded from the registered state.
   always_ff @(posedge in_clk25) begin
      if (in_reset) begin
         pll_rst <= 1'b1;
         sys_rst <= 1'b1;
         ready   <= 1'b0;
         fault   <= 1'b0;
      end else begin
         pll_rst <= (state == ST_PLL_RST) || (state == ST_FAULT);
         sys_rst <= (state != ST_RUN);
         ready   <= (state == ST_RUN);
         fault   <= (state == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with a cycle-level behavioural reference.
module tb_pll_reset_seq;

   localparam int RST = 4;
   localparam int TO  = 20;
   localparam int ST  = 8;
   localparam int MR  = 3;

   logic       in_clk25 = 1'b0;
   logic       in_reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, sys_rst, ready, fault;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int tests = 0;
   int fails = 0;
   int n = 0;
   int at;
   int cnt;

   pll_reset_seq #(
      .RST_CYCLES   (RST),
      .LOCK_TIMEOUT (TO),
      .STABLE_CYCLES(ST),
      .MAX_RETRIES  (MR)
   ) dut (
      .in_clk25     (in_clk25),
      .in_reset     (in_reset),
      .pll_locked   (pll_locked),
      .relock_req   (relock_req),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .fault        (fault),
      .retry_cnt    (retry_cnt),
      .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 in_clk25 = ~in_clk25;

   // Reference: phase plus cycles spent in it; lock seen two edges late.
   localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FLT = 4;
   int   ph, nph, spent, m_retry, m_loss;
   logic h1, h2, ls;
   logic e_pll, e_sys, e_rdy, e_flt;
   logic m_valid = 1'b0;

   always @(posedge in_clk25) begin
      if (in_reset) begin
         ph = P_RST; spent = 0; h1 = 1'b0; h2 = 1'b0;
         m_retry = 0; m_loss = 0;
         e_pll = 1'b1; e_sys = 1'b1; e_rdy = 1'b0; e_flt = 1'b0;
         m_valid = 1'b1;
      end else begin
         ls = h2; h2 = h1; h1 = pll_locked;
         e_pll = (ph == P_RST) || (ph == P_FLT);
         e_sys = (ph != P_RUN);
         e_rdy = (ph == P_RUN);
         e_flt = (ph == P_FLT);
         spent = spent + 1;
         nph = ph;
         if (ph == P_RST && spent == RST) nph = P_WAIT;
         if (ph == P_WAIT) begin
            if (ls) nph = P_STB;
            else if (spent == TO) begin
               m_retry = m_retry + 1;
               nph = (m_retry == MR) ? P_FLT : P_RST;
            end
         end
         if (ph == P_STB) begin
            if (!ls) nph = P_WAIT;
            else if (spent == ST) begin nph = P_RUN; m_retry = 0; end
         end
         if (ph == P_RUN && (!ls || relock_req)) begin
            nph = P_RST;
            if (!ls && m_loss < 255) m_loss = m_loss + 1;
         end
         if (ph == P_FLT && relock_req) begin nph = P_RST; m_retry = 0; end
         if (nph != ph) spent = 0;
         ph = nph;
      end
   end

   always @(negedge in_clk25) begin
      if (m_valid) begin
         tests++;
         if ({pll_rst, sys_rst, ready, fault} !== {e_pll, e_sys, e_rdy, e_flt} ||
             retry_cnt !== 4'(m_retry) || lock_loss_cnt !== 8'(m_loss)) begin
            fails++;
            $display("FAIL model t=%0t: got pll_rst/sys_rst/ready/fault=%b%b%b%b retry=%0d loss=%0d, expected %b%b%b%b retry=%0d loss=%0d",
                     $time, pll_rst, sys_rst, ready, fault, retry_cnt, lock_loss_cnt,
                     e_pll, e_sys, e_rdy, e_flt, m_retry, m_loss);
         end
      end
   end

   task automatic tick();
      @(posedge in_clk25);
      #1;
      n++;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      in_reset = 1'b1;
      tick();
      tick();
      in_reset = 1'b0;
      n = 0;
   endtask

   task automatic wait_until(input string name, input int sel, input logic val,
                             input int budget, output int when);
      when = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (((sel == 0) ? ready : fault) === val) begin
            when = n;
            break;
         end
      end
      if (when < 0) begin
         tests++;
         fails++;
         $display("FAIL %s: no event within %0d cycles", name, budget);
      end
   endtask

   initial begin
      // Locked PLL: 4-cycle PLL reset, release 13 cycles after first edge.
      pll_locked = 1'b1;
      do_reset();
      chk("reset_outs", int'({pll_rst, sys_rst, ready, fault}), 4'b1100);
      chk("reset_cnts", int'({retry_cnt, lock_loss_cnt}), 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("pll_rst_pulse_hi", int'(pll_rst), 1);
      end
      tick();
      chk("pll_rst_pulse_lo", int'(pll_rst), 0);
      wait_until("ready_first", 0, 1'b1, 50, at);
      chk("ready_at", at, 14);
      chk("sys_rst_run", int'(sys_rst), 0);

      // Lock loss in RUN.
      pll_locked = 1'b0;
      repeat (4) tick();
      chk("loss_ready", int'(ready), 0);
      chk("loss_sys_rst", int'(sys_rst), 1);
      chk("loss_pll_rst", int'(pll_rst), 1);
      chk("loss_cnt1", int'(lock_loss_cnt), 1);
      pll_locked = 1'b1;
      wait_until("relock1", 0, 1'b1, 100, at);

      // Relock request coinciding with the synchronised lock drop.
      pll_locked = 1'b0;
      tick();
      tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      pll_locked = 1'b1;
      tick();
      chk("coinc_loss", int'(lock_loss_cnt), 2);
      chk("coinc_pll_rst", int'(pll_rst), 1);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pll_rst) cnt++;
         else break;
      end
      chk("coinc_single_pulse", cnt, 4);
      wait_until("relock2", 0, 1'b1, 100, at);
      chk("coinc_loss_hold", int'(lock_loss_cnt), 2);

      // Relock request alone in RUN: resequence, no loss counted.
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      tick();
      chk("relock_ready", int'(ready), 0);
      chk("relock_loss", int'(lock_loss_cnt), 2);

      // Saturation over 300 losses in total.
      for (int i = 0; i < 298; i++) begin
         wait_until("sat_up", 0, 1'b1, 100, at);
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         wait_until("sat_down", 0, 1'b0, 20, at);
      end
      chk("loss_sat", int'(lock_loss_cnt), 255);

      // Reset while in STABLE.
      repeat (6) tick();
      in_reset = 1'b1;
      tick();
      chk("midrst_outs", int'({pll_rst, sys_rst, ready, fault}), 4'b1100);
      chk("midrst_cnts", int'({retry_cnt, lock_loss_cnt}), 0);
      tick();
      in_reset = 1'b0;
      n = 0;

      // One-cycle lock glitch at stable count 5 forces full requalification.
      repeat (8) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_until("glitch_ready", 0, 1'b1, 60, at);
      chk("glitch_ready_at", at, 21);

      // No lock: three timeouts then FAULT; relock ignored in WAIT_LOCK.
      pll_locked = 1'b0;
      do_reset();
      repeat (10) tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      while (n < 30) tick();
      chk("retry1", int'(retry_cnt), 1);
      while (n < 50) tick();
      chk("retry2", int'(retry_cnt), 2);
      wait_until("fault_rise", 1, 1'b1, 100, at);
      chk("fault_at", at, 73);
      chk("fault_retry", int'(retry_cnt), 3);
      chk("fault_pll_rst", int'(pll_rst), 1);
      repeat (10) tick();
      chk("fault_hold", int'({fault, sys_rst}), 2'b11);
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      chk("fault_exit_retry", int'(retry_cnt), 0);
      tick();
      chk("fault_exit_outs", int'({pll_rst, fault}), 2'b10);

      // Lock arriving in the final timeout cycle wins over the retry.
      do_reset();
      while (n < 21) tick();
      pll_locked = 1'b1;
      wait_until("prio_ready", 0, 1'b1, 60, at);
      chk("prio_ready_at", at, 33);
      chk("prio_retry", int'(retry_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL RST pulse length in in_clk25 cycles (1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: max cycles in WAIT_LOCK before retry (1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: cycles of continuous lock required before release (1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: lock timeouts tolerated before FAULT (1..15).
REQ-005 SHALL have port in_clk25, input, 1: the single clock (25 MHz reference); all logic on its rising edge.
REQ-006 SHALL have port in_reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port pll_locked, input, 1: PLL LOCK, asynchronous to in_clk25.
REQ-008 SHALL have port relock_req, input, 1: single-cycle pulse, synchronous; forces a relock sequence.
REQ-009 SHALL have port pll_rst, output, 1: drives PLL RST, active-high.
REQ-010 SHALL have port sys_rst, output, 1: system reset, active-high, registered.
REQ-011 SHALL have port ready, output, 1: high only in RUN.
REQ-012 SHALL have port fault, output, 1: high only in FAULT.
REQ-013 SHALL have port retry_cnt, output, 4: timeouts since last RUN entry or FAULT exit.
REQ-014 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses in RUN.

Function
REQ-015 SHALL synchronise pll_locked through two flops (locked_s); FSM uses locked_s only.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT with a 16-bit shared cycle counter cleared on every state entry.
REQ-017 PLL_RST: pll_rst=1, sys_rst=1; SHALL last exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, sys_rst=1; locked_s=1 -> STABLE next cycle; counter reaching LOCK_TIMEOUT -> retry_cnt+1, then FAULT if new retry_cnt equals MAX_RETRIES, else PLL_RST.
REQ-019 WAIT_LOCK: locked_s=1 in the timeout cycle SHALL take priority (-> STABLE, no retry counted).
REQ-020 STABLE: sys_rst=1; locked_s=0 in any cycle -> WAIT_LOCK (timeout restarts); STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN.
REQ-021 RUN: sys_rst=0, ready=1; retry_cnt cleared on entry; locked_s=0 -> PLL_RST and lock_loss_cnt+1 (saturate 255).
REQ-022 RUN: relock_req=1 -> PLL_RST; coinciding with locked_s=0 SHALL count one lock loss only.
REQ-023 FAULT: pll_rst=1, sys_rst=1, fault=1; relock_req -> PLL_RST with retry_cnt cleared; otherwise held indefinitely.
REQ-024 relock_req SHALL be ignored in PLL_RST, WAIT_LOCK, STABLE.
REQ-025 sys_rst, ready, fault, pll_rst SHALL be registered outputs decoded from the registered state; no glitches.

Reset
REQ-026 in_reset=1 SHALL, at the next edge and from any state: state=PLL_RST, counter=0, sync flops=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence; the first post-reset cycle restarts PLL_RST timing.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-029 Sub-module sync2 (two-flop synchroniser, reset to 0) SHALL be instantiated for pll_locked.
REQ-030 Estimated RTL size 150-250 lines; no other sub-modules.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-031 pll_locked tied 1, release reset -> pll_rst high 4 cycles, ready=1 and sys_rst=0 exactly 13 cycles after first non-reset edge.
REQ-032 pll_locked tied 0 -> three PLL_RST/WAIT_LOCK rounds, retry_cnt 1,2,3, then fault=1, pll_rst=1; relock_req -> retry_cnt=0, PLL_RST.
REQ-033 In STABLE drop pll_locked 1 cycle at stable count 5 -> return to WAIT_LOCK, ready delayed by full 8-cycle re-qualification.
REQ-034 In RUN drop pll_locked -> ready=0, sys_rst=1 within 3 cycles, lock_loss_cnt=1, full resequence; 300 losses -> lock_loss_cnt=255.
REQ-035 In RUN relock_req same cycle as locked_s falls -> single PLL_RST entry, lock_loss_cnt incremented by exactly 1.
REQ-036 Assert in_reset during STABLE -> next edge all outputs at REQ-026 values.
